anton_neopixel_stream_rx: RTL and testbench

- Receive-side counterpart of the NeoPixel stream controller. Samples a WS2812-style single-wire stream at 7 MHz and classifies each bit by its high-pulse width.
- Assembles 24-bit pixels MSB first and writes them into the pixel buffer via a write port. Buffer addressing uses the same 8/32-bit index stepping and limit rules as the transmit side.
- Detects the reset/latch gap to delimit frames. Used for loopback self-test and for daisy-chain input capture.

---
 rtl/anton_neopixel_stream_rx.sv | 217 +++++++++++++++++++++
 tb/tb_anton_neopixel_stream_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/anton_neopixel_stream_rx.sv
// WS2812-style single-wire receiver: classifies bits by high-pulse width, packs
// 24-bit pixels MSB first into a pixel buffer and delimits frames by the reset gap.
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 255
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module anton_neopixel_stream_rx #(
  parameter int BUFFER_END   = `BUFFER_END_DEFAULT,
  parameter int T1_THRESHOLD = 4,
  parameter int HIGH_MAX     = 7,
  parameter int RESET_CYCLES = 350,
  localparam int BUFFER_BITS = `CLOG2(BUFFER_END+1)
) (
  input  logic                   clk7mhz,
  input  logic                   rst,
  input  logic                   reg_ctrl_run,
  input  logic                   reg_ctrl_32bit,
  input  logic                   reg_ctrl_limit,
  input  logic [12:0]            reg_max,
  input  logic                   err_clear,
  input  logic                   stream_input,
  output logic                   pixel_wr_en,
  output logic [BUFFER_BITS-1:0] pixel_wr_addr,
  output logic [23:0]            pixel_wr_data,
  output logic                   frame_done,
  output logic [BUFFER_BITS:0]   frame_pixels,
  output logic                   err_timing,
  output logic                   err_overflow,
  output logic                   rx_busy,
  output logic [1:0]             dbg_state
);

  localparam int BB = BUFFER_BITS;
  localparam int HW = $clog2(HIGH_MAX + 2);
  localparam int LW = $clog2(RESET_CYCLES + 1);
  localparam logic [HW-1:0] HIGH_SAT  = HW'(HIGH_MAX + 1);
  localparam logic [HW-1:0] HIGH_LIM  = HW'(HIGH_MAX);
  localparam logic [HW-1:0] T1_LIM    = HW'(T1_THRESHOLD);
  localparam logic [LW-1:0] LOW_SAT   = LW'(RESET_CYCLES);
  localparam logic [BB-1:0] INDEX_END = BB'(BUFFER_END);
  localparam logic [BB:0]   CNT_ONE   = (BB+1)'(1);

  typedef enum logic [1:0] {GAP = 2'd0, IDLE = 2'd1, HIGH = 2'd2, LOW = 2'd3} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sample_q;
  logic [HW-1:0]   high_cnt_q, high_cnt_d;
  logic [LW-1:0]   low_cnt_q, low_cnt_d;
  logic [23:0]     shift_q, shift_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [BB-1:0]   pixel_index_q, pixel_index_d;
  logic            overflow_q, overflow_d;
  logic [BB:0]     wr_cnt_q, wr_cnt_d;
  logic            pixel_wr_en_q, pixel_wr_en_d;
  logic [BB-1:0]   pixel_wr_addr_q, pixel_wr_addr_d;
  logic [23:0]     pixel_wr_data_q, pixel_wr_data_d;
  logic            frame_done_q, frame_done_d;
  logic [BB:0]     frame_pixels_q, frame_pixels_d;
  logic            err_timing_q, err_timing_d;
  logic            err_overflow_q, err_overflow_d;

  logic            timing_set, ovf_set, low_gap, bit_val;
  logic [BB-1:0]   index_equiv, index_max, index_step;

  if (BB < 13) begin : g_unused_max
    logic unused_max_bits;
    assign unused_max_bits = ^reg_max[12:BB];
  end

  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    bit_cnt_d       = bit_cnt_q;
    pixel_index_d   = pixel_index_q;
    overflow_d      = overflow_q;
    wr_cnt_d        = wr_cnt_q;
    pixel_wr_en_d   = 1'b0;
    pixel_wr_addr_d = pixel_wr_addr_q;
    pixel_wr_data_d = pixel_wr_data_q;
    frame_done_d    = 1'b0;
    frame_pixels_d  = frame_pixels_q;
    timing_set      = 1'b0;
    ovf_set         = 1'b0;

    // Run-length counters track the synchronised line regardless of state.
    if (sample_q) begin
      high_cnt_d = (high_cnt_q == HIGH_SAT) ? high_cnt_q : high_cnt_q + HW'(1);
      low_cnt_d  = '0;
    end else begin
      high_cnt_d = '0;
      low_cnt_d  = (low_cnt_q == LOW_SAT) ? low_cnt_q : low_cnt_q + LW'(1);
    end
    low_gap = !sample_q && (low_cnt_d == LOW_SAT);
    bit_val = (high_cnt_q >= T1_LIM);

    // In 32-bit mode the limit is compared against the last byte lane of the word.
    index_equiv = reg_ctrl_32bit ? (pixel_index_q | BB'(3)) : pixel_index_q;
    index_max   = reg_ctrl_limit ? reg_max[BB-1:0] : INDEX_END;
    index_step  = reg_ctrl_32bit ? BB'(4) : BB'(1);

    if (!reg_ctrl_run) begin
      state_d       = GAP;
      bit_cnt_d     = '0;
      pixel_index_d = '0;
      overflow_d    = 1'b0;
      wr_cnt_d      = '0;
    end else begin
      case (state_q)
        GAP:  if (low_gap) state_d = IDLE;
        IDLE: if (sample_q) state_d = HIGH;
        HIGH: begin
          if (sample_q) begin
            if (high_cnt_q >= HIGH_LIM) begin
              timing_set    = 1'b1;
              state_d       = GAP;
              bit_cnt_d     = '0;
              pixel_index_d = '0;
              overflow_d    = 1'b0;
              wr_cnt_d      = '0;
            end
          end else begin
            shift_d = {shift_q[22:0], bit_val};
            state_d = LOW;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              if (overflow_q) begin
                ovf_set = 1'b1;
              end else begin
                pixel_wr_en_d   = 1'b1;
                pixel_wr_addr_d = pixel_index_q;
                pixel_wr_data_d = shift_d;
                wr_cnt_d        = wr_cnt_q + CNT_ONE;
                if (index_equiv == index_max) overflow_d = 1'b1;
                else pixel_index_d = pixel_index_q + index_step;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        LOW: begin
          if (sample_q) begin
            state_d = HIGH;
          end else if (low_gap) begin
            state_d        = IDLE;
            frame_done_d   = 1'b1;
            frame_pixels_d = wr_cnt_q;
            timing_set     = (bit_cnt_q != 5'd0);
            bit_cnt_d      = '0;
            pixel_index_d  = '0;
            overflow_d     = 1'b0;
            wr_cnt_d       = '0;
          end
        end
        default: state_d = GAP;
      endcase
    end

    // A set event in the same cycle as err_clear wins.
    err_timing_d   = timing_set | (err_timing_q & ~err_clear);
    err_overflow_d = ovf_set | (err_overflow_q & ~err_clear);
  end

  always_ff @(posedge clk7mhz or posedge rst) begin
    if (rst) begin
      state_q         <= GAP;
      sync1_q         <= 1'b0;
      sample_q        <= 1'b0;
      high_cnt_q      <= '0;
      low_cnt_q       <= '0;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      pixel_index_q   <= '0;
      overflow_q      <= 1'b0;
      wr_cnt_q        <= '0;
      pixel_wr_en_q   <= 1'b0;
      pixel_wr_addr_q <= '0;
      pixel_wr_data_q <= '0;
      frame_done_q    <= 1'b0;
      frame_pixels_q  <= '0;
      err_timing_q    <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      sync1_q         <= stream_input;
      sample_q        <= sync1_q;
      high_cnt_q      <= high_cnt_d;
      low_cnt_q       <= low_cnt_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      pixel_index_q   <= pixel_index_d;
      overflow_q      <= overflow_d;
      wr_cnt_q        <= wr_cnt_d;
      pixel_wr_en_q   <= pixel_wr_en_d;
      pixel_wr_addr_q <= pixel_wr_addr_d;
      pixel_wr_data_q <= pixel_wr_data_d;
      frame_done_q    <= frame_done_d;
      frame_pixels_q  <= frame_pixels_d;
      err_timing_q    <= err_timing_d;
      err_overflow_q  <= err_overflow_d;
    end
  end

  assign pixel_wr_en   = pixel_wr_en_q;
  assign pixel_wr_addr = pixel_wr_addr_q;
  assign pixel_wr_data = pixel_wr_data_q;
  assign frame_done    = frame_done_q;
  assign frame_pixels  = frame_pixels_q;
  assign err_timing    = err_timing_q;
  assign err_overflow  = err_overflow_q;
  assign rx_busy       = (state_q == HIGH) || (state_q == LOW);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_anton_neopixel_stream_rx.sv
// Directed bench for anton_neopixel_stream_rx: drives bit-level waveforms on the
// serial line and checks buffer writes, frame delimiting and sticky error flags.
module tb_anton_neopixel_stream_rx;

  localparam int BB = 8;
  localparam logic [1:0] S_GAP  = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;

  logic          clk = 1'b0;
  logic          rst;
  logic          reg_ctrl_run, reg_ctrl_32bit, reg_ctrl_limit, err_clear, stream_input;
  logic [12:0]   reg_max;
  logic          pixel_wr_en, frame_done, err_timing, err_overflow, rx_busy;
  logic [BB-1:0] pixel_wr_addr;
  logic [23:0]   pixel_wr_data;
  logic [BB:0]   frame_pixels;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int n_frames = 0;
  int frames_before;
  logic [BB-1:0] exp_addr_q[$];
  logic [23:0]   exp_q[$];

  anton_neopixel_stream_rx dut (
    .clk7mhz(clk), .rst(rst), .reg_ctrl_run(reg_ctrl_run), .reg_ctrl_32bit(reg_ctrl_32bit),
    .reg_ctrl_limit(reg_ctrl_limit), .reg_max(reg_max), .err_clear(err_clear),
    .stream_input(stream_input), .pixel_wr_en(pixel_wr_en), .pixel_wr_addr(pixel_wr_addr),
    .pixel_wr_data(pixel_wr_data), .frame_done(frame_done), .frame_pixels(frame_pixels),
    .err_timing(err_timing), .err_overflow(err_overflow), .rx_busy(rx_busy),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #71 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send_bit(input logic b);
    stream_input = 1'b1;
    repeat (b ? 5 : 2) tick();
    stream_input = 1'b0;
    repeat (b ? 3 : 6) tick();
  endtask

  task automatic send_bits(input logic [23:0] v, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(v[i]);
  endtask

  task automatic gap();
    stream_input = 1'b0;
    repeat (360) tick();
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  // Scoreboard: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) n_frames++;
      if (pixel_wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {31'd0, pixel_wr_en}, 32'd0);
        end else begin
          check("wr_addr", {24'd0, pixel_wr_addr}, {24'd0, exp_addr_q.pop_front()});
          check("wr_data", {8'd0, pixel_wr_data}, {8'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    reg_ctrl_run = 1'b1;
    reg_ctrl_32bit = 1'b0;
    reg_ctrl_limit = 1'b0;
    reg_max = 13'd0;
    err_clear = 1'b0;
    stream_input = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_state", dbg_state, S_GAP);
    check("rst_wr_en", pixel_wr_en, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_pixels", frame_pixels, 0);
    check("rst_err_timing", err_timing, 0);
    check("rst_err_overflow", err_overflow, 0);
    check("rst_busy", rx_busy, 0);

    // 347 ticks plus the 2-stage synchroniser fill give a low run of 349 samples
    repeat (347) tick();
    send_bit(1'b1);
    repeat (4) tick();
    check("short_gap_state", dbg_state, S_GAP);
    check("short_gap_busy", rx_busy, 0);
    gap();
    check("full_gap_state", dbg_state, S_IDLE);

    // Single pixel decode
    exp_addr_q.push_back(8'd0); exp_q.push_back(24'hA5C3F0);
    send_bits(24'hA5C3F0, 24);
    check("decode_busy", rx_busy, 1);
    frames_before = n_frames;
    gap();
    check("decode_frames", n_frames, frames_before + 1);
    check("decode_frame_pixels", frame_pixels, 1);
    check("decode_err_timing", err_timing, 0);
    check("decode_err_overflow", err_overflow, 0);
    check("decode_exp_empty", exp_q.size(), 0);

    // 32-bit stepping with software limit: third pixel overflows
    reg_ctrl_32bit = 1'b1;
    reg_ctrl_limit = 1'b1;
    reg_max = 13'd7;
    exp_addr_q.push_back(8'd0); exp_q.push_back(24'h123456);
    exp_addr_q.push_back(8'd4); exp_q.push_back(24'h00FF00);
    send_bits(24'h123456, 24);
    send_bits(24'h00FF00, 24);
    check("ovf_before_third", err_overflow, 0);
    send_bits(24'hFFFFFF, 24);
    frames_before = n_frames;
    gap();
    check("ovf_flag", err_overflow, 1);
    check("ovf_frame_pixels", frame_pixels, 2);
    check("ovf_frames", n_frames, frames_before + 1);
    check("ovf_exp_empty", exp_q.size(), 0);
    pulse_clear();
    check("ovf_cleared", err_overflow, 0);
    reg_ctrl_32bit = 1'b0;
    reg_ctrl_limit = 1'b0;

    // Over-long high pulse mid-pixel aborts the frame without frame_done
    frames_before = n_frames;
    send_bits(24'hF00000, 5);
    stream_input = 1'b1;
    repeat (9) tick();
    stream_input = 1'b0;
    repeat (3) tick();
    check("timing_flag", err_timing, 1);
    check("timing_state", dbg_state, S_GAP);
    gap();
    check("timing_no_frame", n_frames, frames_before);
    check("timing_state_idle", dbg_state, S_IDLE);
    check("timing_pixels_held", frame_pixels, 2);
    exp_addr_q.push_back(8'd0); exp_q.push_back(24'h5A0F81);
    send_bits(24'h5A0F81, 24);
    gap();
    check("recover_frames", n_frames, frames_before + 1);
    check("recover_frame_pixels", frame_pixels, 1);
    check("recover_exp_empty", exp_q.size(), 0);

    // Partial pixel at frame end
    pulse_clear();
    check("timing_cleared", err_timing, 0);
    frames_before = n_frames;
    send_bits(24'hABC000, 12);
    gap();
    check("partial_frames", n_frames, frames_before + 1);
    check("partial_frame_pixels", frame_pixels, 0);
    check("partial_err_timing", err_timing, 1);

    // Receiver disabled mid-frame, then a fresh frame
    pulse_clear();
    frames_before = n_frames;
    send_bits(24'hFFC000, 10);
    reg_ctrl_run = 1'b0;
    repeat (3) tick();
    check("run_off_state", dbg_state, S_GAP);
    check("run_off_busy", rx_busy, 0);
    reg_ctrl_run = 1'b1;
    gap();
    check("run_on_state", dbg_state, S_IDLE);
    check("run_no_frame", n_frames, frames_before);
    exp_addr_q.push_back(8'd0); exp_q.push_back(24'hC0FFEE);
    send_bits(24'hC0FFEE, 24);
    gap();
    check("run_frames", n_frames, frames_before + 1);
    check("run_frame_pixels", frame_pixels, 1);
    check("run_err_timing", err_timing, 0);
    check("run_exp_empty", exp_q.size(), 0);

    // err_clear coinciding with a new timing error: the error is registered on
    // the 10th edge after the line rises
    stream_input = 1'b1;
    repeat (9) tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    stream_input = 1'b0;
    check("clear_vs_set", err_timing, 1);
    repeat (3) tick();
    pulse_clear();
    check("clear_alone", err_timing, 0);
    gap();
    check("final_exp_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
